morty_fetch_unit: RTL
=====================

MORTY_FETCH_UNIT -- requirements
Module: morty_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h8000_0000, which is the PC value after reset.
REQ-002 SHALL have port clk_i  in  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rstn_i  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port if_pc_sel_i  in  2  PC source: 00 sequential, 01 branch, 10 jump, 11 exception.
REQ-005 SHALL have port if_kill_i  in  1  branch/jump redirect request from the control unit.
REQ-006 SHALL have port if_stall_i  in  1  IF stall from the control unit.
REQ-007 SHALL have ports branch_target_i, jump_target_i, exception_target_i  in  32 each  redirect targets.
REQ-008 SHALL have port iwbm_addr_o  out  32  instruction bus address, registered.
REQ-009 SHALL have ports iwbm_cyc_o and iwbm_stb_o  out  1 each  bus cycle and strobe, registered.
REQ-010 SHALL have ports iwbm_dat_i  in  32, iwbm_ack_i  in  1, iwbm_err_i  in  1  bus response.
REQ-011 SHALL have port if_stall_req_o  out  1  high whenever no valid instruction is presented.
REQ-012 SHALL have ports id_instruction_o and id_pc_o  out  32 each  fetched instruction and its PC.
REQ-013 SHALL have ports if_bus_err_o and if_misaligned_o  out  1 each  fault flags qualifying the presented instruction.

Function
REQ-014 SHALL define redirect = if_kill_i | (if_pc_sel_i==11); target is selected by if_pc_sel_i; if_kill_i with sel 00 is ignored.
REQ-015 SHALL implement states IDLE, FETCH, DROP, VALID.
REQ-016 IDLE: cyc/stb low; if pc[1:0]!=0, load NOP 32'h0000_0013 with if_misaligned_o=1 and go to VALID without bus access; otherwise go to FETCH with addr=pc.
REQ-017 FETCH: cyc=stb=1 and addr=pc held until ack or err.
REQ-018 FETCH with ack and no redirect SHALL latch iwbm_dat_i into the buffer and go to VALID.
REQ-019 FETCH with err and no redirect SHALL latch NOP with if_bus_err_o=1 and go to VALID.
REQ-020 FETCH with redirect and no ack/err SHALL load pc<=target and go to DROP.
REQ-021 FETCH with redirect and ack/err in the same cycle SHALL discard the response, load pc<=target, and go to IDLE.
REQ-022 DROP: cyc/stb held; on ack/err the data is discarded and the state goes to IDLE; a further redirect in DROP updates pc and stays in DROP.
REQ-023 VALID: if_stall_req_o=0 and outputs are driven from the buffer; redirect loads pc<=target and goes to IDLE (buffer discarded); otherwise if_stall_i=0 loads pc<=pc+4 and goes to IDLE; otherwise the state holds.
REQ-024 SHALL assert if_stall_req_o=1 in IDLE, FETCH and DROP.
REQ-025 SHALL keep outputs stable while VALID and stalled, regardless of bus input activity.
REQ-026 PC increment SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-027 Best-case throughput SHALL be one instruction per 3 cycles with a single-cycle ack; there SHALL be no bus cycle outstanding while in IDLE or VALID.
REQ-028 Fault flags SHALL be 0 unless set by REQ-016 or REQ-019, and SHALL clear when leaving VALID.

Reset
REQ-029 Asserting rstn_i low SHALL immediately force state=IDLE, pc=RESET_ADDR, cyc=stb=0, addr=RESET_ADDR, buffer=NOP, and flags=0, including in the middle of a bus cycle.
REQ-030 After release, the first iwbm_cyc_o SHALL rise on the second rising clock edge.

Structure
REQ-031 Shared package morty_pkg SHALL hold the state enum, the PC_SEL_SEQ/BRANCH/JUMP/EXC encodings, and the NOP constant.
REQ-032 SHALL be a single module with no sub-module.

Verification
REQ-033 Reset release with ack one cycle after stb and if_stall_i=0 -> addresses 8000_0000, 8000_0004, 8000_0008 fetched, each presented one cycle with if_stall_req_o=0.
REQ-034 Jump (sel=10, if_kill_i=1, target 8000_0100) during FETCH at 8000_0008 with ack 3 cycles late -> DROP, stale data never presented, next fetch at 8000_0100.
REQ-035 VALID with if_stall_i=1 for 5 cycles -> instruction and PC unchanged, no bus cycle issued, advance to pc+4 after release.
REQ-036 iwbm_err_i on fetch at 8000_0010 -> id_instruction_o=0000_0013, if_bus_err_o=1; exception redirect to 8000_0004 -> next fetch at 8000_0004.
REQ-037 Branch target 8000_0102 -> no bus cycle, if_misaligned_o=1, NOP presented.
REQ-038 rstn_i low while cyc=1 -> cyc/stb drop without clock edge; pc=8000_0000 after release.

Source files
------------

// File: rtl/morty_pkg.sv
// rtl/morty_pkg.sv - shared types and constants for the morty instruction fetch unit
package morty_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_DROP  = 2'b10,
      ST_VALID = 2'b11
   } fetch_state_t;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_EXC    = 2'b11;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/morty_fetch_unit.sv
// rtl/morty_fetch_unit.sv - single-beat instruction fetch over a Wishbone-style bus
// with redirect handling, a one-entry instruction buffer and fault flags.
module morty_fetch_unit
   import morty_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [1:0]  if_pc_sel_i,
   input  logic        if_kill_i,
   input  logic        if_stall_i,
   input  logic [31:0] branch_target_i,
   input  logic [31:0] jump_target_i,
   input  logic [31:0] exception_target_i,
   output logic [31:0] iwbm_addr_o,
   output logic        iwbm_cyc_o,
   output logic        iwbm_stb_o,
   input  logic [31:0] iwbm_dat_i,
   input  logic        iwbm_ack_i,
   input  logic        iwbm_err_i,
   output logic        if_stall_req_o,
   output logic [31:0] id_instruction_o,
   output logic [31:0] id_pc_o,
   output logic        if_bus_err_o,
   output logic        if_misaligned_o
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_addr;
   logic         r_cyc;
   logic         r_stb;
   logic [31:0]  r_buf;
   logic         r_bus_err;
   logic         r_misaligned;
   logic         r_armed;

   fetch_state_t w_state_nxt;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_addr_nxt;
   logic         w_cyc_nxt;
   logic [31:0]  w_buf_nxt;
   logic         w_bus_err_nxt;
   logic         w_misaligned_nxt;

   logic         w_redirect;
   logic [31:0]  w_target;
   logic         w_resp;
   logic [31:0]  w_pc_inc;

   // A kill with the sequential selector carries no target, so it is not a redirect.
   assign w_redirect = (if_kill_i && (if_pc_sel_i != PC_SEL_SEQ)) || (if_pc_sel_i == PC_SEL_EXC);
   assign w_resp     = iwbm_ack_i | iwbm_err_i;
   assign w_pc_inc   = r_pc + 32'd4;

   always_comb begin
      w_target = r_pc;
      case (if_pc_sel_i)
         PC_SEL_BRANCH: w_target = branch_target_i;
         PC_SEL_JUMP:   w_target = jump_target_i;
         PC_SEL_EXC:    w_target = exception_target_i;
         default:       w_target = r_pc;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_ADDR;
         r_addr       <= RESET_ADDR;
         r_cyc        <= 1'b0;
         r_stb        <= 1'b0;
         r_buf        <= NOP;
         r_bus_err    <= 1'b0;
         r_misaligned <= 1'b0;
         r_armed      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_addr       <= w_addr_nxt;
         r_cyc        <= w_cyc_nxt;
         r_stb        <= w_cyc_nxt;
         r_buf        <= w_buf_nxt;
         r_bus_err    <= w_bus_err_nxt;
         r_misaligned <= w_misaligned_nxt;
         r_armed      <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_addr_nxt       = r_addr;
      w_cyc_nxt        = r_cyc;
      w_buf_nxt        = r_buf;
      w_bus_err_nxt    = r_bus_err;
      w_misaligned_nxt = r_misaligned;

      case (r_state)
         ST_IDLE: begin
            w_cyc_nxt = 1'b0;
            // The first edge after reset release only arms the unit.
            if (r_armed) begin
               if (r_pc[1:0] != 2'b00) begin
                  w_buf_nxt        = NOP;
                  w_misaligned_nxt = 1'b1;
                  w_state_nxt      = ST_VALID;
               end else begin
                  w_addr_nxt  = r_pc;
                  w_cyc_nxt   = 1'b1;
                  w_state_nxt = ST_FETCH;
               end
            end
         end

         ST_FETCH: begin
            if (w_redirect) begin
               w_pc_nxt = w_target;
               if (w_resp) begin
                  w_cyc_nxt   = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DROP;
               end
            end else if (iwbm_ack_i) begin
               w_buf_nxt   = iwbm_dat_i;
               w_cyc_nxt   = 1'b0;
               w_state_nxt = ST_VALID;
            end else if (iwbm_err_i) begin
               w_buf_nxt     = NOP;
               w_bus_err_nxt = 1'b1;
               w_cyc_nxt     = 1'b0;
               w_state_nxt   = ST_VALID;
            end
         end

         ST_DROP: begin
            // The outstanding cycle must complete before a new address can be issued.
            if (w_redirect) begin
               w_pc_nxt = w_target;
            end
            if (w_resp) begin
               w_cyc_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end

         ST_VALID: begin
            if (w_redirect) begin
               w_pc_nxt         = w_target;
               w_bus_err_nxt    = 1'b0;
               w_misaligned_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end else if (!if_stall_i) begin
               w_pc_nxt         = w_pc_inc;
               w_bus_err_nxt    = 1'b0;
               w_misaligned_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
         end

         default: begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign iwbm_addr_o      = r_addr;
   assign iwbm_cyc_o       = r_cyc;
   assign iwbm_stb_o       = r_stb;
   assign if_stall_req_o   = (r_state != ST_VALID);
   assign id_instruction_o = r_buf;
   assign id_pc_o          = r_pc;
   assign if_bus_err_o     = r_bus_err;
   assign if_misaligned_o  = r_misaligned;

endmodule
